mmss_timer_ctrl: RTL
====================

// Module: mmss_timer_ctrl
// PURPOSE
//   Controller for a cascaded MM:SS display counter built from four BCD digit counters (mod-10/mod-6/mod-10/mod-6).
//   Divides clk down to a 1-per-TICK_DIV advance tick, sequences start/stop/clear/set, and resolves the whole carry chain
//   in one cycle. It sits between the front-panel pulse inputs and the 7-seg display driver.
// PARAMETERS
//   TICK_DIV   100   clk cycles per count advance; legal range 2..2^16.
// PORTS
//   clk        in   1   single clock; all state updates on its rising edge
//   rst        in   1   synchronous, active-high reset
//   start      in   1   one-cycle pulse: begin/resume counting
//   stop       in   1   one-cycle pulse: pause counting
//   clear      in   1   one-cycle pulse: zero all digits, return to IDLE
//   set_en     in   1   level: hold high to enter/stay in SET mode
//   set_sel    in   2   digit to edit in SET: 0=sec_ones 1=sec_tens 2=min_ones 3=min_tens
//   set_inc    in   1   one-cycle pulse: increment the selected digit (SET only)
//   sec_ones   out  4   BCD 0..9
//   sec_tens   out  3   0..5
//   min_ones   out  4   BCD 0..9
//   min_tens   out  3   0..5
//   sec_carry  out  1   one-cycle pulse: seconds wrapped 59->00
//   min_wrap   out  1   one-cycle pulse: display wrapped 59:59->00:00
//   running    out  1   high while state==RUN
//   state      out  2   00 IDLE, 01 RUN, 10 PAUSE, 11 SET
// BEHAVIOUR
//   Reset: all digits 0, prescaler 0, sec_carry/min_wrap 0, running 0, state IDLE.
//   Input priority in every state: clear > set_en > stop > start.
//   FSM transitions:
//     any --clear--> IDLE.
//     IDLE/PAUSE --set_en--> SET.
//     SET --!set_en--> IDLE.
//     RUN --stop--> PAUSE.
//     IDLE/PAUSE --start--> RUN.
//     start in RUN, stop in IDLE/PAUSE: ignored.
//     set_en in RUN: ignored until a stop.
//   Prescaler: counts 0..TICK_DIV-1 only in RUN. tick = (prescaler==TICK_DIV-1)&&RUN.
//     Wraps to 0 on tick. Held (phase kept) in PAUSE. Forced to 0 on clear and on entry to SET or IDLE.
//   Advance: on tick, sec_ones increments. Each digit at its max with incoming carry wraps to 0 and carries on.
//     The full chain (e.g. 09:59->10:00) settles at the same edge. No multi-cycle ripple.
//   Pulses: sec_carry/min_wrap are registered and high for exactly the cycle in which the wrapped digits first show.
//     min_wrap implies sec_carry.
//   Stop on tick cycle: the tick still advances (stop takes effect next edge). Clear on tick cycle: clear wins, no pulses.
//   SET: set_inc adds 1 to the selected digit modulo its range (9 or 5). Never carries.
//     sec_carry/min_wrap stay 0. set_inc outside SET is ignored.
//   rst mid-operation: same as reset at the next edge, regardless of state or pending pulses.
// CONFIGURATION
//   MMSS_ALARM_EN defined:
//     adds input alarm_val[13:0] = {min_tens,min_ones,sec_tens,sec_ones}, same widths as the outputs.
//     adds output alarm: a one-cycle registered pulse in the cycle the display first equals alarm_val after a RUN tick.
//     No pulse from SET edits or clear.
//   MMSS_ALARM_EN undefined: neither port nor the comparator logic exists.
// STRUCTURE
//   Package mmss_pkg: state encoding localparams (ST_IDLE..ST_SET); digit max constants ONES_MAX=9, TENS_MAX=5;
//     set_sel digit index constants.
//   Sub-module bcd_digit_cnt #(MAX,W): clk, rst, clr, inc, set_inc -> q[W-1:0], co.
//     co = inc && q==MAX (combinational). set_inc wraps without co. Instantiated 4x.
//   This module holds the FSM, prescaler, carry-chain wiring, pulse registers and the optional alarm comparator.
// TESTING  (TICK_DIV=4 unless noted)
//   rst, start, run 4*60 cycles -> display 01:00. sec_carry pulses once, in the cycle display reads 01:00. running=1.
//   Preset 59:59 via SET, exit, start -> after 4 cycles display 00:00. sec_carry=min_wrap=1 for one cycle.
//   Start, stop after 6 cycles, hold 20 cycles, start -> next advance 2 cycles after resume (phase kept). Display frozen while paused.
//   SET, set_sel=1, 7x set_inc -> sec_tens 0,1,..5,0,1. Other digits unchanged. No pulses.
//   clear asserted with start and stop at a tick cycle -> IDLE, 00:00, no pulses. rst while in RUN at 12:34 -> 00:00, IDLE next cycle.
//   MMSS_ALARM_EN, alarm_val=00:03 -> alarm pulses once at 00:03. SET to 00:03 gives no pulse.

Source files
------------

// File: rtl/mmss_pkg.sv
// Shared constants for the MM:SS timer: state encoding, digit limits, SET digit selectors.
// Latency: n/a (constants and a pure next-digit helper).
// Backpressure: n/a.
package mmss_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_SET   = 2'b11;

    localparam int ONES_MAX = 9;
    localparam int TENS_MAX = 5;

    localparam logic [1:0] SEL_SEC_ONES = 2'd0;
    localparam logic [1:0] SEL_SEC_TENS = 2'd1;
    localparam logic [1:0] SEL_MIN_ONES = 2'd2;
    localparam logic [1:0] SEL_MIN_TENS = 2'd3;

    // Value a digit will hold after this edge, used to predict the display one cycle ahead.
    function automatic logic [3:0] bcd_next(input logic [3:0] q, input logic inc, input logic [3:0] max);
        if (!inc) return q;
        return (q == max) ? 4'd0 : q + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single wrapping digit counter 0..MAX; co flags a wrap on the run-time increment path only.
// Latency: q updates one edge after inc/set_inc; co is combinational.
// Backpressure: none, every increment is accepted.
module bcd_digit_cnt #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         set_inc,
    output logic [W-1:0] q,
    output logic         co
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         at_max;

    assign at_max = (q_q == W'(MAX));

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc || set_inc) begin
            q_d = at_max ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign co = inc && at_max;

endmodule

// File: rtl/mmss_timer_ctrl.sv
// MM:SS timer controller: FSM, prescaler, single-cycle carry chain, wrap pulses; MMSS_ALARM_EN adds an alarm comparator.
// Latency: display and pulses update on the edge after the tick; state changes one edge after a command pulse.
// Backpressure: none; command pulses that are illegal in the current state are dropped.
module mmss_timer_ctrl
    import mmss_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        set_en,
    input  logic [1:0]  set_sel,
    input  logic        set_inc,
    output logic [3:0]  sec_ones,
    output logic [2:0]  sec_tens,
    output logic [3:0]  min_ones,
    output logic [2:0]  min_tens,
    output logic        sec_carry,
    output logic        min_wrap,
    output logic        running,
    output logic [1:0]  state
`ifdef MMSS_ALARM_EN
    ,
    input  logic [13:0] alarm_val,
    output logic        alarm
`endif
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sec_carry_q, min_wrap_q;
    logic          tick, adv, set_act;
    logic          so_co, st_co, mo_co, mt_co;

    assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    // clear beats a same-cycle tick: no advance, no pulses
    assign adv     = tick && !clear;
    assign set_act = (state_q == ST_SET) && set_inc && !clear;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (set_en)     state_d = ST_SET;
                    else if (start) state_d = ST_RUN;
                end
                ST_RUN:  if (stop)    state_d = ST_PAUSE;
                ST_SET:  if (!set_en) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // PAUSE keeps the phase so a resume lands on the same sub-second position.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end else if (state_d == ST_IDLE || state_d == ST_SET) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            sec_carry_q <= 1'b0;
            min_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_carry_q <= st_co;
            min_wrap_q  <= mt_co;
        end
    end

    bcd_digit_cnt #(.MAX(ONES_MAX), .W(4)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(adv),
        .set_inc(set_act && set_sel == SEL_SEC_ONES), .q(sec_ones), .co(so_co)
    );
    bcd_digit_cnt #(.MAX(TENS_MAX), .W(3)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(so_co),
        .set_inc(set_act && set_sel == SEL_SEC_TENS), .q(sec_tens), .co(st_co)
    );
    bcd_digit_cnt #(.MAX(ONES_MAX), .W(4)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(st_co),
        .set_inc(set_act && set_sel == SEL_MIN_ONES), .q(min_ones), .co(mo_co)
    );
    bcd_digit_cnt #(.MAX(TENS_MAX), .W(3)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(mo_co),
        .set_inc(set_act && set_sel == SEL_MIN_TENS), .q(min_tens), .co(mt_co)
    );

    assign sec_carry = sec_carry_q;
    assign min_wrap  = min_wrap_q;
    assign running   = (state_q == ST_RUN);
    assign state     = state_q;

`ifdef MMSS_ALARM_EN
    logic       alarm_q;
    logic       alarm_d;
    logic [3:0] so_n, st_n, mo_n, mt_n;

    // Compare against the post-edge display so the pulse lines up with the digits it matches.
    always_comb begin
        so_n    = bcd_next(sec_ones, adv, 4'(ONES_MAX));
        st_n    = bcd_next({1'b0, sec_tens}, so_co, 4'(TENS_MAX));
        mo_n    = bcd_next(min_ones, st_co, 4'(ONES_MAX));
        mt_n    = bcd_next({1'b0, min_tens}, mo_co, 4'(TENS_MAX));
        alarm_d = adv
                  && (so_n == alarm_val[3:0])
                  && (st_n == {1'b0, alarm_val[6:4]})
                  && (mo_n == alarm_val[10:7])
                  && (mt_n == {1'b0, alarm_val[13:11]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule
